// File: rtl/live_sim_pkg.sv
// live_sim_pkg: shared types and helpers for the multi-channel live gate.
// Holds the channel state enum and effective period/on resolution.
package live_sim_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    RUN,
    DONE
  } ch_state_e;

  typedef struct packed {
    logic [MAX_W-1:0] period;
    logic [MAX_W-1:0] on;
  } eff_t;

  // A zero period selects the built-in default gate.
  function automatic eff_t resolve(
    input logic [MAX_W-1:0] per,
    input logic [MAX_W-1:0] on,
    input logic [MAX_W-1:0] def_p,
    input logic [MAX_W-1:0] def_on
  );
    eff_t r;
    if (per == '0) begin
      r.period = def_p;
      r.on     = def_on;
    end else begin
      r.period = per;
      r.on     = on;
    end
    return r;
  endfunction

endpackage

// File: rtl/live_sim_multi_if.sv
// live_sim_multi_if: control/config and status bundle of the live gate.
// Per-channel fields are packed, channel i at [i*W +: W].
interface live_sim_multi_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int SC_W  = 16
);

  logic [N_CH-1:0]       ena;
  logic [N_CH-1:0]       oneshot;
  logic [N_CH-1:0]       clr_cnt;
  logic [N_CH*CNT_W-1:0] cfg_period;
  logic [N_CH*CNT_W-1:0] cfg_on;
  logic [N_CH*CNT_W-1:0] cfg_offset;
  logic [N_CH-1:0]       out_live;
  logic [N_CH-1:0]       spill_start;
  logic [N_CH-1:0]       done;
  logic [N_CH*SC_W-1:0]  spill_cnt;

  modport master (
    output ena, oneshot, clr_cnt,
    output cfg_period, cfg_on, cfg_offset,
    input  out_live, spill_start, done,
    input  spill_cnt
  );

  modport slave (
    input  ena, oneshot, clr_cnt,
    input  cfg_period, cfg_on, cfg_offset,
    output out_live, spill_start, done,
    output spill_cnt
  );

endinterface

// File: rtl/live_sim_chan.sv
// live_sim_chan: one live-gate channel with offset, period, on-time,
// one-shot mode and a saturating spill counter.
module live_sim_chan
  import live_sim_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int          SC_W       = 16,
  parameter int unsigned DEF_PERIOD = 750000000,
  parameter int unsigned DEF_ON     = 562500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             oneshot,
  input  logic             clr_cnt,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_on,
  input  logic [CNT_W-1:0] cfg_offset,
  output logic             out_live,
  output logic             spill_start,
  output logic             done,
  output logic [SC_W-1:0]  spill_cnt
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [SC_W-1:0]  SONE = SC_W'(1);

  ch_state_e        state, state_n;
  logic             pre_ena;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] sh_per, sh_per_n;
  logic [CNT_W-1:0] sh_on, sh_on_n;
  logic [CNT_W-1:0] sh_off, sh_off_n;
  logic             live_n, start_n, done_n;
  eff_t             eff;

  assign eff = resolve(MAX_W'(cfg_period), MAX_W'(cfg_on),
                       MAX_W'(DEF_PERIOD), MAX_W'(DEF_ON));

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sh_per_n = sh_per;
    sh_on_n  = sh_on;
    sh_off_n = sh_off;
    if (!ena) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!pre_ena) begin
            sh_per_n = CNT_W'(eff.period);
            sh_on_n  = CNT_W'(eff.on);
            sh_off_n = cfg_offset;
            cnt_n    = '0;
            state_n  = (cfg_offset != '0) ? DELAY : RUN;
          end
        end
        DELAY: begin
          if (cnt == sh_off - ONE) begin
            cnt_n   = '0;
            state_n = RUN;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
        RUN: begin
          if (cnt >= sh_per - ONE) begin
            cnt_n = '0;
            if (oneshot) begin
              state_n = DONE;
            end else begin
              sh_per_n = CNT_W'(eff.period);
              sh_on_n  = CNT_W'(eff.on);
            end
          end else begin
            cnt_n = cnt + ONE;
          end
        end
        DONE: state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
    // Outputs are registered from next-state values so the gate
    // lines up with the cycle the counter value belongs to.
    live_n  = (state_n == RUN) && (cnt_n < sh_on_n);
    start_n = (state_n == RUN) && (cnt_n == '0) && (sh_on_n != '0);
    done_n  = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pre_ena     <= 1'b0;
      cnt         <= '0;
      sh_per      <= '0;
      sh_on       <= '0;
      sh_off      <= '0;
      out_live    <= 1'b0;
      spill_start <= 1'b0;
      done        <= 1'b0;
      spill_cnt   <= '0;
    end else begin
      state       <= state_n;
      pre_ena     <= ena;
      cnt         <= cnt_n;
      sh_per      <= sh_per_n;
      sh_on       <= sh_on_n;
      sh_off      <= sh_off_n;
      out_live    <= live_n;
      spill_start <= start_n;
      done        <= done_n;
      if (clr_cnt) begin
        spill_cnt <= '0;
      end else if (start_n && (spill_cnt != '1)) begin
        spill_cnt <= spill_cnt + SONE;
      end
    end
  end

endmodule

// File: rtl/live_sim_multi.sv
// live_sim_multi: N_CH independent live-gate channels.
// Slices the packed config buses and concatenates the status buses.
module live_sim_multi
  import live_sim_pkg::*;
#(
  parameter int          N_CH       = 4,
  parameter int          CNT_W      = 32,
  parameter int          SC_W       = 16,
  parameter int unsigned DEF_PERIOD = 750000000,
  parameter int unsigned DEF_ON     = 562500000
) (
  input  logic             clk,
  input  logic             rst,
  live_sim_multi_if.slave  bus
);

  logic [N_CH-1:0]      live_w;
  logic [N_CH-1:0]      start_w;
  logic [N_CH-1:0]      done_w;
  logic [N_CH*SC_W-1:0] cnt_w;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    live_sim_chan #(
      .CNT_W      (CNT_W),
      .SC_W       (SC_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_ON     (DEF_ON)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .ena         (bus.ena[i]),
      .oneshot     (bus.oneshot[i]),
      .clr_cnt     (bus.clr_cnt[i]),
      .cfg_period  (bus.cfg_period[i*CNT_W +: CNT_W]),
      .cfg_on      (bus.cfg_on[i*CNT_W +: CNT_W]),
      .cfg_offset  (bus.cfg_offset[i*CNT_W +: CNT_W]),
      .out_live    (live_w[i]),
      .spill_start (start_w[i]),
      .done        (done_w[i]),
      .spill_cnt   (cnt_w[i*SC_W +: SC_W])
    );
  end

  assign bus.out_live    = live_w;
  assign bus.spill_start = start_w;
  assign bus.done        = done_w;
  assign bus.spill_cnt   = cnt_w;

endmodule

// File: tb/tb_live_sim_multi.sv
// tb_live_sim_multi: directed stimulus with a spill_start scoreboard
// and per-cycle gate/done checks against a small timing model.
module tb_live_sim_multi;

  localparam int N_CH   = 4;
  localparam int CNT_W  = 32;
  localparam int SC_W   = 4;
  localparam int DEF_P  = 20;
  localparam int DEF_ON = 15;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sbq[N_CH][$];
  exp_t me;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  live_sim_multi_if #(
    .N_CH(N_CH), .CNT_W(CNT_W), .SC_W(SC_W)
  ) bus ();

  live_sim_multi #(
    .N_CH(N_CH), .CNT_W(CNT_W), .SC_W(SC_W),
    .DEF_PERIOD(DEF_P), .DEF_ON(DEF_ON)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [SC_W-1:0] cnt_of(input int ch);
    return bus.spill_cnt[ch*SC_W +: SC_W];
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (bus.spill_start[ch]) begin
          if (sbq[ch].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL start_ch%0d: unexpected spill_start at %0d",
                     ch, cyc);
          end else begin
            me = sbq[ch].pop_front();
            chk($sformatf("start_cyc_ch%0d", ch), 64'(cyc), 64'(me.cyc));
            chk($sformatf("start_cnt_ch%0d", ch),
                64'(cnt_of(ch)), 64'(me.cnt));
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cfg(input int ch, input int per, input int on,
                     input int off, input bit os);
    bus.cfg_period[ch*CNT_W +: CNT_W] = per;
    bus.cfg_on[ch*CNT_W +: CNT_W]     = on;
    bus.cfg_offset[ch*CNT_W +: CNT_W] = off;
    bus.oneshot[ch]                   = os;
  endtask

  task automatic start(input int ch, output int t0);
    bus.ena[ch] = 1'b1;
    t0 = cyc + 1;
  endtask

  task automatic push(input int ch, input int t, input int c);
    exp_t e;
    e.cyc = t;
    e.cnt = c;
    sbq[ch].push_back(e);
  endtask

  task automatic stop(input int ch);
    bus.ena[ch] = 1'b0;
    step();
    chk($sformatf("stop_live_ch%0d", ch), 64'(bus.out_live[ch]), 0);
    chk($sformatf("stop_done_ch%0d", ch), 64'(bus.done[ch]), 0);
  endtask

  task automatic watch(input int ch, input int n, input int t0,
                       input int per, input int on, input int off,
                       input bit os);
    int k, m;
    bit el, ed;
    for (int i = 0; i < n; i++) begin
      step();
      k  = cyc - t0;
      el = 1'b0;
      ed = 1'b0;
      if (k >= off) begin
        m = k - off;
        if (os && m >= per) ed = 1'b1;
        else el = (m % per) < on;
      end
      chk($sformatf("live_ch%0d_k%0d", ch, k),
          64'(bus.out_live[ch]), 64'(el));
      chk($sformatf("done_ch%0d_k%0d", ch, k),
          64'(bus.done[ch]), 64'(ed));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int t, k, m;
    rst             = 1'b1;
    bus.ena         = '1;
    bus.oneshot     = '0;
    bus.clr_cnt     = '0;
    bus.cfg_period  = '0;
    bus.cfg_on      = '0;
    bus.cfg_offset  = '0;

    repeat (3) begin
      step();
      chk("rst_flags", 64'({bus.out_live, bus.spill_start, bus.done}), 0);
      chk("rst_cnt", 64'(bus.spill_cnt), 0);
    end
    rst     = 1'b0;
    bus.ena = '0;
    repeat (3) begin
      step();
      chk("idle_flags", 64'({bus.out_live, bus.spill_start, bus.done}), 0);
      chk("idle_cnt", 64'(bus.spill_cnt), 0);
    end

    cfg(0, 10, 6, 0, 0);
    start(0, t);
    for (int j = 0; j < 5; j++) push(0, t + 10 * j, j + 1);
    watch(0, 50, t, 10, 6, 0, 0);
    chk("cont_cnt5", 64'(cnt_of(0)), 5);
    stop(0);
    chk("hold_cnt", 64'(cnt_of(0)), 5);

    cfg(1, 10, 6, 3, 1);
    start(1, t);
    push(1, t + 3, 1);
    watch(1, 20, t, 10, 6, 3, 1);
    chk("oneshot_cnt", 64'(cnt_of(1)), 1);
    stop(1);

    cfg(2, 10, 6, 0, 0);
    start(2, t);
    push(2, t, 1);
    push(2, t + 10, 2);
    push(2, t + 18, 3);
    push(2, t + 26, 4);
    for (int i = 0; i < 29; i++) begin
      step();
      k = cyc - t;
      m = (k < 10) ? k : (k - 10) % 8;
      chk($sformatf("recfg_live_k%0d", k),
          64'(bus.out_live[2]), 64'(m < 6));
      if (k == 4) bus.cfg_period[2*CNT_W +: CNT_W] = 8;
    end
    stop(2);

    cfg(3, 10, 0, 0, 0);
    start(3, t);
    watch(3, 30, t, 10, 0, 0, 0);
    chk("on0_cnt", 64'(cnt_of(3)), 0);
    stop(3);

    cfg(3, 10, 12, 0, 0);
    start(3, t);
    for (int j = 0; j < 3; j++) push(3, t + 10 * j, j + 1);
    watch(3, 25, t, 10, 12, 0, 0);
    stop(3);

    cfg(3, 0, 3, 0, 0);
    start(3, t);
    for (int j = 0; j < 3; j++) push(3, t + DEF_P * j, j + 4);
    watch(3, 45, t, DEF_P, DEF_ON, 0, 0);
    stop(3);

    bus.clr_cnt[0] = 1'b1;
    step();
    bus.clr_cnt[0] = 1'b0;
    chk("clr_cnt", 64'(cnt_of(0)), 0);
    cfg(0, 10, 6, 0, 0);
    start(0, t);
    for (int j = 0; j < 20; j++)
      push(0, t + 10 * j, (j + 1 > 15) ? 15 : j + 1);
    push(0, t + 200, 0);
    watch(0, 196, t, 10, 6, 0, 0);
    chk("sat_cnt", 64'(cnt_of(0)), 15);
    watch(0, 4, t, 10, 6, 0, 0);
    bus.clr_cnt[0] = 1'b1;
    step();
    bus.clr_cnt[0] = 1'b0;
    chk("clr_win_cnt", 64'(cnt_of(0)), 0);
    chk("clr_win_live", 64'(bus.out_live[0]), 1);
    step();
    chk("clr_hold_cnt", 64'(cnt_of(0)), 0);
    stop(0);

    repeat (3) step();
    for (int ch = 0; ch < N_CH; ch++)
      chk($sformatf("sb_drain_ch%0d", ch), 64'(sbq[ch].size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/live_sim_multi.md
Name: live_sim_multi

Overview:
- Multi-channel, run-time-configurable successor to the single-channel live (spill-gate) simulator.
- Each channel generates a periodic live gate of programmable period, on-time and start offset, with continuous or one-shot mode.
- Each channel counts generated spills and flags spill starts.
- Sits beside the trigger/mem control logic in the Top CDT and drives emulated LIVE inputs for bench and beam-off running.

Parameters:
N_CH, 4, number of independent channels
CNT_W, 32, width of period/on/offset counters
SC_W, 16, width of per-channel spill counter
DEF_PERIOD, 750000000, period used when cfg_period of a channel is 0
DEF_ON, 562500000, on-time used when cfg_period of a channel is 0

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ena  in  N_CH  per-channel enable; level, rising edge starts the channel
oneshot  in  N_CH  per-channel mode: 1 = single spill then DONE, 0 = continuous
clr_cnt  in  N_CH  per-channel synchronous clear of spill_cnt
cfg_period  in  N_CH*CNT_W  per-channel period in clk cycles; channel i at [i*CNT_W +: CNT_W]
cfg_on  in  N_CH*CNT_W  per-channel on-time in cycles
cfg_offset  in  N_CH*CNT_W  per-channel delay from enable to first spill
out_live  out  N_CH  registered live gate
spill_start  out  N_CH  one-cycle pulse, coincident with each 0->1 of out_live
done  out  N_CH  high while a one-shot channel is in DONE
spill_cnt  out  N_CH*SC_W  per-channel spill count, saturating

Behaviour:
- Reset: all outputs 0, all channels in IDLE, counters 0, pre_ena 0. Reset has priority over every other input.
- Per-channel FSM states: IDLE, DELAY, RUN, DONE.
- IDLE:
  - ena rising edge (ena & ~pre_ena) latches cfg_period/cfg_on/cfg_offset into shadow registers.
  - Next state is DELAY if offset > 0, otherwise RUN with cnt = 0.
- DELAY: counts offset cycles, then enters RUN with cnt = 0.
- RUN:
  - cnt runs 0..P-1 and wraps to 0; spill length is exactly P cycles.
  - out_live = (cnt < ON), registered.
  - With offset 0, out_live is first high in the cycle after ena is first sampled high.
  - At wrap: if oneshot, go to DONE; otherwise reload the shadow from live cfg_* inputs. Config changes therefore take effect only at a period boundary.
- DONE: out_live 0, done 1. Stays until ena falls, then goes to IDLE; a new rising edge is required to restart.
- ena low in any state: go to IDLE next cycle; out_live, spill_start and done drop to 0 on that edge. spill_cnt is held.
- Effective period:
  - cfg_period == 0 uses DEF_PERIOD and DEF_ON.
  - cfg_on >= P gives out_live constantly high in RUN, with one spill_start per period.
  - cfg_on == 0 gives no gate, no spill_start and no spill_cnt increment.
- spill_start:
  - Pulses when cnt == 0 in RUN and ON > 0. Also pulses at each wrap, including when on >= P (gate stays high).
  - spill_cnt increments on the same cycle and saturates at 2^SC_W-1.
- clr_cnt coincident with spill_start: the clear wins, and spill_cnt reads 0.
- Channels are fully independent; no cross-channel arbitration.
- Counter compares are unsigned CNT_W; the offset counter is the same width.

Decomposition:
- Package live_sim_pkg holds the state enum (IDLE/DELAY/RUN/DONE) and a function resolving effective period/on from cfg and DEF_*.
- Sub-module live_sim_chan implements one channel: FSM, shadow registers, counters, spill counter.
- Top generates N_CH instances and slices/concatenates the packed buses.

Test Plan:
- Reset/idle: rst for 3 cycles with ena=all 1 -> all outputs 0 during reset; after release, all channels wait for a fresh rising edge.
- Continuous ch0, period=10, on=6, offset=0:
  - out_live high 6 cycles, low 4, repeating.
  - spill_start every 10 cycles.
  - spill_cnt = 5 after 50 cycles.
- Offset/one-shot ch1, period=10, on=6, offset=3, oneshot=1:
  - First out_live 4 cycles after enable edge, high 6 cycles.
  - done=1 from cycle 13 after enable onward; spill_cnt=1.
- Mid-run reconfig ch2, cfg_period 10->8 changed at cnt=4:
  - Current spill completes at 10 cycles.
  - Next spill lasts 8 cycles.
- Boundary cases:
  - on=0 -> no gate, spill_cnt stays 0.
  - on=12 with period=10 -> gate constantly high, spill_start every 10.
  - cfg_period=0 -> spill_start spacing equals DEF_PERIOD (bench overrides DEF_PERIOD=20, DEF_ON=15).
- Saturation/clear, SC_W=4: run 20 spills -> spill_cnt holds 15. Then clr_cnt coincident with spill_start -> spill_cnt=0.
